// File: rtl/deser_align_ctrl.sv
// rtl/deser_align_ctrl.sv - LVDS lane training sequencer: bitslip search, word-phase lock, lock monitor
module deser_align_ctrl #(
    parameter logic [23:0] TRAIN_WORD = 24'hF0A55A,
    parameter int          MATCH_CNT  = 8,
    parameter int          CHECK_LEN  = 64,
    parameter int          SETTLE_CYC = 4,
    parameter int          ERR_THRESH = 4
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic       train_start_i,
    input  logic       train_en_i,
    input  logic [7:0] byte_in_i,
    output logic       bitslip_o,
    output logic [1:0] word_phase_o,
    output logic       word_valid_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic       busy_o,
    output logic [3:0] slip_cnt_o
);

    localparam int CYC_W = $clog2(CHECK_LEN);
    localparam int SET_W = $clog2(SETTLE_CYC);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CHECK_LEN - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [3:0]       MATCH_LIM = 4'(MATCH_CNT);
    localparam logic [3:0]       ERR_LAST  = 4'(ERR_THRESH - 1);
    localparam logic [3:0]       SLIP_MAX  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAIL
    } state_t;

    state_t           state_q;
    logic [1:0]       ph_q;
    logic [7:0]       d1_q, d2_q;
    logic [SET_W-1:0] set_cnt_q;
    logic [CYC_W-1:0] cyc_cnt_q;
    logic [3:0]       match_cnt_q, err_cnt_q, slip_cnt_q;
    logic [1:0]       cand_q, word_phase_q;
    logic             cand_valid_q, locked_q, fail_q, bitslip_q;

    logic       match;
    logic       cand_hit;
    logic [3:0] match_cnt_d;
    logic       cand_valid_d;
    logic [1:0] cand_d;
    logic       lock_now;

    // Candidate tracking: the first match picks the phase, later matches only count at that phase.
    always_comb begin
        match        = ({d2_q, d1_q, byte_in_i} == TRAIN_WORD);
        cand_hit     = cand_valid_q && (ph_q == cand_q);
        match_cnt_d  = match_cnt_q;
        cand_valid_d = cand_valid_q;
        cand_d       = cand_q;
        if (!cand_valid_q) begin
            if (match) begin
                cand_d       = ph_q;
                cand_valid_d = 1'b1;
                match_cnt_d  = 4'd1;
            end
        end else if (cand_hit) begin
            if (match) begin
                match_cnt_d = match_cnt_q + 4'd1;
            end else begin
                match_cnt_d  = 4'd0;
                cand_valid_d = 1'b0;
            end
        end
        lock_now = (match_cnt_d == MATCH_LIM);
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ph_q         <= 2'd0;
            d1_q         <= 8'd0;
            d2_q         <= 8'd0;
            set_cnt_q    <= '0;
            cyc_cnt_q    <= '0;
            match_cnt_q  <= 4'd0;
            err_cnt_q    <= 4'd0;
            slip_cnt_q   <= 4'd0;
            cand_q       <= 2'd0;
            cand_valid_q <= 1'b0;
            word_phase_q <= 2'd0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            bitslip_q    <= 1'b0;
        end else begin
            ph_q      <= (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
            d2_q      <= d1_q;
            d1_q      <= byte_in_i;
            bitslip_q <= 1'b0;
            if (train_start_i) begin
                state_q    <= S_SETTLE;
                set_cnt_q  <= '0;
                locked_q   <= 1'b0;
                fail_q     <= 1'b0;
                slip_cnt_q <= 4'd0;
                err_cnt_q  <= 4'd0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_SETTLE: begin
                        if (set_cnt_q == SET_LAST) begin
                            state_q      <= S_CHECK;
                            cyc_cnt_q    <= '0;
                            match_cnt_q  <= 4'd0;
                            cand_valid_q <= 1'b0;
                        end else begin
                            set_cnt_q <= set_cnt_q + SET_W'(1);
                        end
                    end
                    S_CHECK: begin
                        cyc_cnt_q    <= cyc_cnt_q + CYC_W'(1);
                        match_cnt_q  <= match_cnt_d;
                        cand_valid_q <= cand_valid_d;
                        cand_q       <= cand_d;
                        if (lock_now) begin
                            state_q      <= S_LOCKED;
                            locked_q     <= 1'b1;
                            word_phase_q <= cand_d;
                            err_cnt_q    <= 4'd0;
                        end else if (cyc_cnt_q == CYC_LAST) begin
                            if (slip_cnt_q == SLIP_MAX) begin
                                state_q <= S_FAIL;
                                fail_q  <= 1'b1;
                            end else begin
                                state_q    <= S_SLIP;
                                bitslip_q  <= 1'b1;
                                slip_cnt_q <= slip_cnt_q + 4'd1;
                            end
                        end
                    end
                    S_SLIP: begin
                        state_q   <= S_SETTLE;
                        set_cnt_q <= '0;
                    end
                    S_LOCKED: begin
                        if (train_en_i && (ph_q == word_phase_q)) begin
                            if (match) begin
                                err_cnt_q <= 4'd0;
                            end else if (err_cnt_q == ERR_LAST) begin
                                state_q    <= S_SETTLE;
                                set_cnt_q  <= '0;
                                locked_q   <= 1'b0;
                                slip_cnt_q <= 4'd0;
                                err_cnt_q  <= 4'd0;
                            end else begin
                                err_cnt_q <= err_cnt_q + 4'd1;
                            end
                        end
                    end
                    S_FAIL: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bitslip_o    = bitslip_q;
    assign word_phase_o = word_phase_q;
    assign word_valid_o = locked_q && (ph_q == word_phase_q);
    assign locked_o     = locked_q;
    assign fail_o       = fail_q;
    assign busy_o       = (state_q == S_SETTLE) || (state_q == S_CHECK) || (state_q == S_SLIP);
    assign slip_cnt_o   = slip_cnt_q;

endmodule

// File: tb/tb_deser_align_ctrl.sv
// tb/tb_deser_align_ctrl.sv - self-checking bench for deser_align_ctrl with a bitslip-aware stream model
module tb_deser_align_ctrl;

    localparam int SETTLE_CYC = 4;
    localparam int CHECK_LEN  = 64;
    localparam int MATCH_CNT  = 8;
    localparam int SPACING    = SETTLE_CYC + CHECK_LEN + 1;

    logic       clk_div = 1'b0;
    logic       rst_n = 1'b0;
    logic       train_start_i = 1'b0;
    logic       train_en_i = 1'b1;
    logic [7:0] byte_in_i = 8'd0;
    logic       bitslip_o, word_valid_o, locked_o, fail_o, busy_o;
    logic [1:0] word_phase_o;
    logic [3:0] slip_cnt_o;

    deser_align_ctrl dut (
        .clk_div      (clk_div),
        .rst_n        (rst_n),
        .train_start_i(train_start_i),
        .train_en_i   (train_en_i),
        .byte_in_i    (byte_in_i),
        .bitslip_o    (bitslip_o),
        .word_phase_o (word_phase_o),
        .word_valid_o (word_valid_o),
        .locked_o     (locked_o),
        .fail_o       (fail_o),
        .busy_o       (busy_o),
        .slip_cnt_o   (slip_cnt_o)
    );

    always #5 clk_div = ~clk_div;

    typedef struct {
        int off;
        bit rnd;
        int exp_slips;
        bit exp_locked;
        bit exp_fail;
    } vec_t;

    logic [23:0] tw = 24'hF0A55A;
    int   tests = 0, fails = 0;
    int   cyc = 0, k = 0, off = 0, nslip = 0, bs_double = 0, last_bs = -1, corrupt_left = 0;
    bit   prev_bs = 0, rnd = 0;
    logic [7:0] w0 = 8'd0, w1 = 8'd0, w2 = 8'd0;

    function automatic logic [7:0] gen(input logic [23:0] word, input int kk, input int oo);
        logic [7:0] b;
        int p;
        p = 8 * kk + oo;
        for (int j = 0; j < 8; j++) b[7-j] = word[23 - ((p + j) % 24)];
        return b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clk_div cycle: react to BITSLIP like the ISERDESE2 would, then drive the next byte.
    task automatic tick();
        @(posedge clk_div);
        #1;
        cyc++;
        if (bitslip_o) begin
            if (prev_bs) bs_double++;
            if (last_bs >= 0) check("bitslip_spacing", cyc - last_bs, SPACING);
            last_bs = cyc;
            nslip++;
            off++;
        end
        prev_bs = bitslip_o;
        k++;
        w2 = w1;
        w1 = w0;
        w0 = rnd ? 8'($urandom_range(0, 255)) : gen(tw, k, off);
        if (corrupt_left > 0 && word_valid_o) begin
            w0 = w0 ^ 8'hFF;
            corrupt_left--;
        end
        byte_in_i = w0;
    endtask

    task automatic start();
        train_start_i = 1'b1;
        tick();
        train_start_i = 1'b0;
    endtask

    task automatic wait_lock(input string name, input int budget);
        int n;
        n = 0;
        while (!locked_o && n < budget) begin
            tick();
            n++;
        end
        check(name, locked_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[6];
        int   n, m_at, lock_at, mcount, wp0, sl;

        vec[0] = '{0, 1'b0, 0, 1'b1, 1'b0};
        vec[1] = '{3, 1'b0, 5, 1'b1, 1'b0};
        vec[2] = '{7, 1'b0, 1, 1'b1, 1'b0};
        vec[3] = '{5, 1'b0, 3, 1'b1, 1'b0};
        vec[4] = '{1, 1'b0, 7, 1'b1, 1'b0};
        vec[5] = '{0, 1'b1, 8, 1'b0, 1'b1};

        repeat (3) tick();
        check("reset_outputs", {bitslip_o, word_phase_o, word_valid_o, locked_o, fail_o, busy_o, slip_cnt_o}, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_outputs", {bitslip_o, word_phase_o, word_valid_o, locked_o, fail_o, busy_o, slip_cnt_o}, 0);

        for (int i = 0; i < 6; i++) begin
            rnd = vec[i].rnd;
            off = vec[i].off;
            nslip = 0;
            last_bs = -1;
            bs_double = 0;
            start();
            check($sformatf("v%0d_busy_after_start", i), busy_o, 1);
            n = 0;
            while (!(locked_o || fail_o) && n < 2000) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_slips", i), nslip, vec[i].exp_slips);
            check($sformatf("v%0d_slip_cnt", i), slip_cnt_o, vec[i].exp_slips);
            check($sformatf("v%0d_locked", i), locked_o, vec[i].exp_locked);
            check($sformatf("v%0d_fail", i), fail_o, vec[i].exp_fail);
            check($sformatf("v%0d_busy", i), busy_o, 0);
            if (vec[i].exp_locked) begin
                wp0 = word_phase_o;
                for (int j = 0; j < 9; j++) begin
                    tick();
                    check($sformatf("v%0d_word_valid", i), word_valid_o, int'({w2, w1, w0} == tw));
                    check($sformatf("v%0d_word_phase", i), word_phase_o, wp0);
                end
            end else begin
                sl = nslip;
                repeat (150) tick();
                check($sformatf("v%0d_no_more_slips", i), nslip, sl);
                check($sformatf("v%0d_fail_sticky", i), fail_o, 1);
                check($sformatf("v%0d_idle_in_fail", i), busy_o, 0);
            end
            check($sformatf("v%0d_bitslip_width", i), bs_double, 0);
        end

        // Restart out of FAIL onto an aligned stream.
        rnd = 1'b0;
        off = 0;
        start();
        check("fail_cleared_by_start", fail_o, 0);
        check("fail_start_busy", busy_o, 1);
        check("fail_start_slip_cnt", slip_cnt_o, 0);
        wait_lock("relock_after_fail", 500);
        check("relock_after_fail_slips", slip_cnt_o, 0);

        // Three corrupted words are tolerated, four drop lock.
        corrupt_left = 3;
        n = 0;
        while (corrupt_left > 0 && n < 100) begin tick(); n++; end
        repeat (12) tick();
        check("lock_held_3_errors", locked_o, 1);
        corrupt_left = 4;
        n = 0;
        while (corrupt_left > 0 && n < 100) begin tick(); n++; end
        check("lock_before_4th_error", locked_o, 1);
        tick();
        check("lock_lost_4_errors", locked_o, 0);
        check("retrain_busy", busy_o, 1);
        wait_lock("relock_after_errors", 500);
        check("relock_after_errors_slips", slip_cnt_o, 0);

        // With train_en low errors are not counted.
        train_en_i = 1'b0;
        corrupt_left = 6;
        n = 0;
        while (corrupt_left > 0 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        check("lock_held_train_en_low", locked_o, 1);
        train_en_i = 1'b1;

        // Restart out of LOCKED; locked must rise exactly one cycle after the MATCH_CNT-th match.
        start();
        check("locked_cleared_by_start", locked_o, 0);
        check("locked_start_busy", busy_o, 1);
        n = 0; mcount = 0; m_at = -1; lock_at = -1;
        while (n < 300) begin
            tick();
            n++;
            if (locked_o) begin
                lock_at = n;
                break;
            end
            if (n >= SETTLE_CYC && {w2, w1, w0} == tw) begin
                mcount++;
                if (mcount == MATCH_CNT) m_at = n;
            end
        end
        check("lock_latency", lock_at, m_at + 1);
        check("lock_latency_matches", mcount, MATCH_CNT);

        // Asynchronous reset in the middle of a CHECK window after two slips.
        rnd = 1'b1;
        nslip = 0;
        last_bs = -1;
        start();
        n = 0;
        while (nslip < 2 && n < 500) begin tick(); n++; end
        repeat (20) tick();
        check("pre_reset_slip_cnt", slip_cnt_o, 2);
        check("pre_reset_busy", busy_o, 1);
        @(posedge clk_div);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {bitslip_o, word_phase_o, word_valid_o, locked_o, fail_o, busy_o, slip_cnt_o}, 0);
        sl = nslip;
        repeat (2) tick();
        check("held_reset_outputs", {bitslip_o, word_phase_o, word_valid_o, locked_o, fail_o, busy_o, slip_cnt_o}, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_after_release", {bitslip_o, word_phase_o, word_valid_o, locked_o, fail_o, busy_o, slip_cnt_o}, 0);
        check("no_slip_across_reset", nslip, sl);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
